// File: rtl/lfsr_seq_checker.sv
// Locks onto a loadable-LFSR output stream, predicts each next sample and flags mispredictions.
// Define LFSR_CHK_ERRCNT_EN to build the saturating error counter; otherwise err_cnt is tied to 0.
module lfsr_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] seq,
    input  logic             seq_vld,
    input  logic             seq_ld,
    input  logic [WIDTH-1:0] seq_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] exp_val,
    output logic [1:0]       state
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ref_val;
    logic [MW-1:0]    match_cnt;
    logic [LW-1:0]    miss_cnt;
    logic             hit;
    logic             miss_locked;

    assign state       = state_q;
    assign exp_val     = seq_ld ? (ref_val ^ seq_data)
                                : {ref_val[WIDTH-1] ^ ref_val[0], ref_val[WIDTH-1:1]};
    assign hit         = (seq == exp_val);
    assign miss_locked = seq_vld && (state_q == LOCKED) && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            ref_val   <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (seq_vld) begin
                case (state_q)
                    HUNT: begin
                        // An all-zero sample is the LFSR lock-up value and cannot seed a prediction.
                        if (seq != '0) begin
                            ref_val   <= seq;
                            match_cnt <= '0;
                            state_q   <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        ref_val <= seq;
                        if (!hit) begin
                            match_cnt <= '0;
                        end else if (match_cnt == LOCK_LAST) begin
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                            state_q   <= LOCKED;
                            locked    <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            ref_val  <= seq;
                            miss_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                            if (miss_cnt == LOSS_LAST) begin
                                state_q   <= HUNT;
                                locked    <= 1'b0;
                                ref_val   <= '0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                // Flywheel on the prediction so one corrupt sample does not derail tracking.
                                ref_val  <= exp_val;
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_CHK_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_base;

    // Clear takes effect before the increment, so clear plus error in one cycle yields 1.
    assign err_base = err_clr ? '0 : err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (miss_locked) begin
            err_cnt_q <= (err_base == '1) ? err_base : err_base + 1'b1;
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_inputs;
    assign unused_err_inputs = err_clr ^ miss_locked;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: directed test-plan steps then randomized samples
// checked against a sample-level behavioural model. Two instances share stimulus (ERR_W 8 and 2).
module tb_lfsr_seq_checker;

    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] seq;
    logic       seq_vld;
    logic       seq_ld;
    logic [3:0] seq_data;
    logic       err_clr;

    logic       locked, s_locked, err, s_err;
    logic [7:0] err_cnt;
    logic [1:0] s_err_cnt;
    logic [3:0] exp_val, s_exp_val;
    logic [1:0] state, s_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0=HUNT 1=VERIFY 2=LOCKED, counts kept as plain integers.
    int         m_phase, m_match, m_miss, m_cnt, m_scnt;
    logic [3:0] m_ref;
    logic       m_err;

    lfsr_seq_checker #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .seq(seq), .seq_vld(seq_vld), .seq_ld(seq_ld),
        .seq_data(seq_data), .err_clr(err_clr), .locked(locked), .err(err),
        .err_cnt(err_cnt), .exp_val(exp_val), .state(state)
    );

    lfsr_seq_checker #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .seq(seq), .seq_vld(seq_vld), .seq_ld(seq_ld),
        .seq_data(seq_data), .err_clr(err_clr), .locked(s_locked), .err(s_err),
        .err_cnt(s_err_cnt), .exp_val(s_exp_val), .state(s_state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] step(input logic [3:0] r);
        return {r[3] ^ r[0], r[3:1]};
    endfunction

    function automatic logic [3:0] predict(input logic [3:0] r, input logic ld, input logic [3:0] d);
        return ld ? (r ^ d) : step(r);
    endfunction

    function automatic int cnt_exp(input int c);
`ifdef LFSR_CHK_ERRCNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_scnt = 0;
        m_ref = 4'h0; m_err = 1'b0;
    endtask

    task automatic model_sample(input logic [3:0] s, input logic ld, input logic [3:0] d, input logic clr);
        logic [3:0] pred;
        pred  = predict(m_ref, ld, d);
        m_err = 1'b0;
        if (clr) begin
            m_cnt = 0; m_scnt = 0;
        end
        case (m_phase)
            0: if (s != 4'h0) begin
                m_ref = s; m_match = 0; m_phase = 1;
            end
            1: begin
                m_ref = s;
                if (s == pred) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_phase = 2; m_miss = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end
            default: begin
                if (s == pred) begin
                    m_ref = s; m_miss = 0;
                end else begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    if (m_scnt < 3) m_scnt++;
                    m_ref = pred;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_phase = 0; m_ref = 4'h0; m_match = 0; m_miss = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"},   32'(state),     32'(m_phase));
        check({tag, "_locked"},  32'(locked),    32'(m_phase == 2));
        check({tag, "_err"},     32'(err),       32'(m_err));
        check({tag, "_errcnt"},  32'(err_cnt),   32'(cnt_exp(m_cnt)));
        check({tag, "_serrcnt"}, 32'(s_err_cnt), 32'(cnt_exp(m_scnt)));
        check({tag, "_expval"},  32'(exp_val),   32'(predict(m_ref, seq_ld, seq_data)));
        check({tag, "_sstate"},  32'(s_state),   32'(m_phase));
    endtask

    task automatic feed(input string tag, input logic [3:0] s, input logic ld, input logic [3:0] d,
                        input logic clr);
        @(negedge clk);
        seq = s; seq_vld = 1'b1; seq_ld = ld; seq_data = d; err_clr = clr;
        @(posedge clk);
        model_sample(s, ld, d, clr);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        seq_vld = 1'b0; seq_ld = 1'b0; err_clr = 1'b0; seq = 4'($urandom_range(0, 15));
        @(posedge clk);
        m_err = 1'b0;
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        seq_vld = 1'b0; seq_ld = 1'b0; err_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_state"},   32'(state),     32'd0);
        check({tag, "_locked"},  32'(locked),    32'd0);
        check({tag, "_errcnt"},  32'(err_cnt),   32'd0);
        check({tag, "_serrcnt"}, 32'(s_err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock_seq(input string tag);
        feed({tag, "_s0"}, 4'b0001, 1'b0, 4'h0, 1'b0);
        check({tag, "_verify"}, 32'(state), 32'd1);
        feed({tag, "_s1"}, 4'b1000, 1'b0, 4'h0, 1'b0);
        feed({tag, "_s2"}, 4'b1100, 1'b0, 4'h0, 1'b0);
        feed({tag, "_s3"}, 4'b1110, 1'b0, 4'h0, 1'b0);
        check({tag, "_locked"}, 32'(locked), 32'd1);
        feed({tag, "_s4"}, 4'b1111, 1'b0, 4'h0, 1'b0);
        check({tag, "_exp0111"}, 32'(exp_val), 32'b0111);
    endtask

    initial begin
        rst_n = 1'b0; seq = 4'h0; seq_vld = 1'b0; seq_ld = 1'b0; seq_data = 4'h0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset");

        lock_seq("lock");

        feed("single_bad", 4'b0000, 1'b0, 4'h0, 1'b0);
        check("single_err_pulse", 32'(err), 32'd1);
        check("single_flywheel", 32'(exp_val), 32'b1011);
        feed("single_recover", 4'b1011, 1'b0, 4'h0, 1'b0);
        check("single_still_locked", 32'(locked), 32'd1);

        feed("loss_bad1", step(m_ref) ^ 4'b0100, 1'b0, 4'h0, 1'b0);
        feed("loss_bad2", step(m_ref) ^ 4'b0010, 1'b0, 4'h0, 1'b0);
        check("loss_hunt", 32'(state), 32'd0);
        feed("hunt_zero", 4'b0000, 1'b0, 4'h0, 1'b0);
        idle("gap");

        async_reset("rst_a");
        lock_seq("ld_lock");
        feed("load_match", 4'b1100, 1'b1, 4'b0011, 1'b0);
        check("load_no_err", 32'(err), 32'd0);
        async_reset("rst_b");
        lock_seq("ld2_lock");
        feed("load_miss", 4'b1101, 1'b1, 4'b0011, 1'b0);
        check("load_err", 32'(err), 32'd1);

        async_reset("rst_c");
        lock_seq("sat_lock");
        for (int i = 0; i < 5; i++) begin
            feed("sat_bad", step(m_ref) ^ 4'b0001, 1'b0, 4'h0, 1'b0);
            feed("sat_good", step(m_ref), 1'b0, 4'h0, 1'b0);
        end
        check("sat_full", 32'(s_err_cnt), 32'(cnt_exp(3)));
        feed("clr_with_err", step(m_ref) ^ 4'b1000, 1'b0, 4'h0, 1'b1);
        check("clr_then_count", 32'(s_err_cnt), 32'(cnt_exp(1)));
        async_reset("rst_locked");

        for (int i = 0; i < 600; i++) begin
            int r;
            logic ld;
            logic [3:0] d, s;
            r  = $urandom_range(0, 99);
            ld = ($urandom_range(0, 3) == 0);
            d  = 4'($urandom_range(0, 15));
            if (r < 2) begin
                async_reset("rnd_rst");
            end else if (r < 12) begin
                idle("rnd_idle");
            end else begin
                if (m_phase == 0 || $urandom_range(0, 9) >= 8) s = 4'($urandom_range(0, 15));
                else s = predict(m_ref, ld, d);
                feed("rnd", s, ld, d, ($urandom_range(0, 19) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Downstream consumer of the loadable LFSR counter. It samples the counter's output stream, locks onto the sequence, and from then on predicts every next value, including load steps (`count ^ data`). It flags mismatches, counts them in a saturating error counter, and drops lock after repeated misses. It is the self-check stage that sits directly after the counter in the test and BIST path.

## Interface
- `WIDTH`, 4: counter width; must match the upstream counter.
- `LOCK_CNT`, 3: consecutive correct predictions needed to lock (≥1).
- `LOSS_CNT`, 2: consecutive mispredictions while locked before lock is dropped (≥1).
- `ERR_W`, 8: width of the error counter.

Ports:
- `clk` input, 1: single clock; all logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `seq` input, WIDTH: counter output being checked.
- `seq_vld` input, 1: `seq` holds a new value this cycle and is sampled.
- `seq_ld` input, 1: this sample was produced by a load step, not a shift step.
- `seq_data` input, WIDTH: load data for that load step; only meaningful when `seq_ld`=1.
- `err_clr` input, 1: synchronous clear of `err_cnt`.
- `locked` output, 1: FSM is in LOCKED.
- `err` output, 1: one-cycle pulse on a misprediction while locked.
- `err_cnt` output, ERR_W: saturating error count.
- `exp_val` output, WIDTH: value predicted for the next sample.
- `state` output, 2: FSM state (HUNT=00, VERIFY=01, LOCKED=10).

## Operation
- Step functions:
  - Shift: `step(r) = {r[W-1]^r[0], r[W-1:1]}`.
  - Load: `r ^ seq_data`.
  - `exp_val` = `seq_ld` ? `ref ^ seq_data` : `step(ref)`. It is combinational from `ref`, `seq_ld` and `seq_data`.
- Only cycles with `seq_vld`=1 are processed. Otherwise all state holds and `err`=0.
- HUNT:
  - A nonzero sample is captured into `ref`, `match_cnt` is set to 0, and the FSM goes to VERIFY.
  - An all-zero sample is ignored; the FSM stays in HUNT.
- VERIFY:
  - Sample == `exp_val`: `ref` = sample and `match_cnt`++. When `match_cnt` reaches LOCK_CNT, go to LOCKED with `miss_cnt` = 0.
  - Mismatch: reseed `ref` = sample, `match_cnt` = 0, stay in VERIFY. No `err` pulse.
- LOCKED:
  - Match: `ref` = sample, `miss_cnt` = 0.
  - Mismatch:
    - Pulse `err` and increment `err_cnt`; `err_cnt` saturates at 2^ERR_W−1.
    - Flywheel: `ref` = `exp_val`, not the bad sample.
    - `miss_cnt`++. When `miss_cnt` reaches LOSS_CNT, go to HUNT and clear `ref` and both counters.
- `err_clr`:
  - Zeroes `err_cnt`.
  - If an error increments in the same cycle, `err_cnt` becomes 1: clear is applied first, then the count.
  - It does not affect the FSM.
- Reset values: `state`=HUNT, `ref`=0, `match_cnt`=`miss_cnt`=0, `locked`=0, `err`=0, `err_cnt`=0.
- Reset mid-operation returns to HUNT immediately (asynchronously) and loses any partial lock progress.

## Timing
- All outputs except `exp_val` are registered and update on the same rising edge that samples `seq`.
- `err` is high for exactly the one cycle after the offending sample edge.
- `locked` rises on the edge that consumes the LOCK_CNT-th consecutive match. With LOCK_CNT=3 that is the 4th valid sample after HUNT: 1 seed plus 3 matches.
- `locked` falls on the edge of the LOSS_CNT-th consecutive miss. That same edge also pulses `err`.
- Back-to-back `seq_vld` is fully supported. Gaps of any length between samples are allowed.

## Configuration
- `LFSR_CHK_ERRCNT_EN` defined:
  - `err_cnt` is implemented as described.
- `LFSR_CHK_ERRCNT_EN` undefined:
  - No counter register is built and `err_cnt` is tied to 0.
  - `err_clr` is ignored.
  - `err`, `locked` and the FSM are unchanged.

## Test plan
Conditions: WIDTH=4, LOCK_CNT=3, LOSS_CNT=2.
- Lock: after reset, feed shift samples 0001, 1000, 1100, 1110 → `state` 01 after 0001, `locked`=1 after 1110, `err` never high. Then 1111 → still locked and `exp_val`=0111.
- Single error: while locked at `ref`=1111, feed 0000 → `err` pulses once, `err_cnt`=1, `exp_val`=1011 (flywheel). Then 1011 → match, `locked` stays 1.
- Loss: while locked, feed two consecutive wrong values → `err` pulses twice, `err_cnt`+2, `state`=HUNT and `locked`=0 after the second. A zero sample in HUNT then leaves `state`=00.
- Load step: locked at `ref`=1111, feed `seq_ld`=1, `seq_data`=0011, `seq`=1100 → match, no `err`. The same stimulus with `seq`=1101 → `err`.
- Saturation and clear: ERR_W=2, force 5 errors with `err_clr`=0 → `err_cnt`=3. Then `err_clr`=1 together with an error → `err_cnt`=1. Also assert `rst_n`=0 while locked → `state`=00 and `err_cnt`=0 without waiting for a clock edge.
- Macro off: repeat the single-error case without `LFSR_CHK_ERRCNT_EN` → `err` pulses and `err_cnt` stays 0.
